// File: rtl/fixed_accumulate.sv
`default_nettype none
// ============================================================================
// Module   : fixed_accumulate
// Brief    : Sequential Q(wholeWidth).(fractionWidth) accumulator. Sums
//            termCount signed terms, one per calculate_en strobe, and presents
//            the registered total with a one-cycle sum_valid pulse.
// Option   : FIXED_ACCUMULATE_SATURATION_EN - when defined, the final total
//            is clamped to the signed W-bit range and overflow flags a clamp;
//            when undefined, sum wraps and overflow is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module fixed_accumulate #(
  parameter int wholeWidth    = 16,
  parameter int fractionWidth = 16,
  parameter int termCount     = 8
) (
  input  logic                                  clock,
  input  logic                                  reset_n,
  input  logic                                  calculate_en,
  input  logic [wholeWidth+fractionWidth-1:0]   product,
  input  logic                                  clear,
  output logic [wholeWidth+fractionWidth-1:0]   sum,
  output logic                                  sum_valid,
  output logic                                  busy,
  output logic                                  overflow
);

  // Word width, guard bits and the widths derived from them.
  localparam int W  = wholeWidth + fractionWidth;
  localparam int G  = $clog2(termCount);
  localparam int AW = W + G;
  localparam int CW = G + 1;

  // Count value held when the next accepted term is the last one of a group.
  localparam logic [CW-1:0] LAST_CNT = CW'(termCount - 1);

  typedef enum logic [0:0] {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [AW-1:0]   acc_q,   acc_d;
  logic [CW-1:0]   cnt_q,   cnt_d;
  logic [W-1:0]    sum_q,   sum_d;
  logic            valid_q, valid_d;
  logic            ovf_q,   ovf_d;

  // Sign-extended incoming term and the running total including it. All
  // terms share one binary point, so this is plain integer addition.
  logic [AW-1:0]   w_term_ext;
  logic [AW-1:0]   w_acc_sum;
  logic [W-1:0]    w_res_sum;
  logic            w_res_ovf;

  assign w_term_ext = {{G{product[W-1]}}, product};
  assign w_acc_sum  = acc_q + w_term_ext;

`ifdef FIXED_ACCUMULATE_SATURATION_EN
  // The total fits in W bits only when the guard bits and the W-bit sign
  // bit are all equal.
  logic [G:0]      w_top;
  logic            w_fits;

  assign w_top  = w_acc_sum[AW-1:W-1];
  assign w_fits = (&w_top) | ~(|w_top);

  // Clamp an out-of-range total towards the side indicated by its true sign.
  always_comb begin
    w_res_sum = w_acc_sum[W-1:0];
    w_res_ovf = 1'b0;
    if (!w_fits) begin
      w_res_ovf = 1'b1;
      if (w_acc_sum[AW-1]) begin
        w_res_sum = {1'b1, {(W-1){1'b0}}};
      end else begin
        w_res_sum = {1'b0, {(W-1){1'b1}}};
      end
    end
  end
`else
  // Wrap-around result: the guard bits are dropped and never flagged.
  logic            w_unused_hi;

  assign w_res_sum   = w_acc_sum[W-1:0];
  assign w_res_ovf   = 1'b0;
  assign w_unused_hi = ^w_acc_sum[AW-1:W];
`endif

  // State register: asynchronous reset returns every register to zero/IDLE.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
      sum_q   <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      sum_q   <= sum_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  // Next-state logic: clear beats a strobe; the last term publishes the
  // result and returns to IDLE so a term on the following cycle starts anew.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    if (clear) begin
      state_d = ST_IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else if (calculate_en) begin
      case (state_q)
        ST_IDLE: begin
          acc_d   = w_term_ext;
          cnt_d   = CW'(1);
          state_d = ST_ACCUM;
        end
        ST_ACCUM: begin
          if (cnt_q == LAST_CNT) begin
            sum_d   = w_res_sum;
            ovf_d   = w_res_ovf;
            valid_d = 1'b1;
            acc_d   = '0;
            cnt_d   = '0;
            state_d = ST_IDLE;
          end else begin
            acc_d   = w_acc_sum;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
      endcase
    end
  end

  assign sum       = sum_q;
  assign sum_valid = valid_q;
  assign busy      = (state_q == ST_ACCUM);
  assign overflow  = ovf_q;

endmodule
`default_nettype wire

// File: doc/fixed_accumulate.md
# fixed_accumulate

Sequential fixed-point accumulator that sits directly downstream of the `mul` stage. It consumes the registered `product` stream one term per `calculate_en` strobe and sums a fixed number of terms. It emits the registered total with a one-cycle valid pulse, which gives dot-product / MAC capability on the same Q(wholeWidth).(fractionWidth) two's-complement format used by `add`, `sub` and `mul`.

## Interface
- `wholeWidth`, 16, integer bits of the signed fixed-point word (sign included).
- `fractionWidth`, 16, fraction bits.
- `termCount`, 8, number of terms per accumulation; legal range 2..256.
- `clock`  input  1  single clock; all state on rising edge.
- `reset_n`  input  1  asynchronous, active-low reset.
- `calculate_en`  input  1  term-valid strobe; `product` is sampled on the same edge.
- `product`  input  W  signed term, W = wholeWidth+fractionWidth; connects to `mul.product`.
- `clear`  input  1  synchronous abort of the current accumulation.
- `sum`  output  W  registered result; holds until the next result.
- `sum_valid`  output  1  one-cycle pulse when `sum` updates.
- `busy`  output  1  high while a partial accumulation is held.
- `overflow`  output  1  registered with `sum`; high if the true total is outside the W-bit range.

## Operation
- Internal accumulator width is W+G, where G = $clog2(termCount). Terms are sign-extended, so the internal sum never overflows.
- Term counter `cnt` is $clog2(termCount)+1 bits wide.
- States:
  - IDLE: `busy`=0. `calculate_en` loads acc = sext(product), cnt = 1, and moves to ACCUM.
  - ACCUM: `busy`=1. Each `calculate_en` does acc += sext(product), cnt++. When the accepted term is term number termCount, the stage registers `sum`/`overflow`, pulses `sum_valid` next cycle, and returns to IDLE.
- `clear` has priority over `calculate_en`. It forces IDLE and drops the partial sum and count. It produces no `sum_valid`, and `sum` and `overflow` keep their old values. A `calculate_en` on the same cycle as `clear` is discarded.
- A term arriving on the cycle `sum_valid` is high is accepted as term 1 of the next group. Back-to-back groups therefore need no gaps.
- Fixed-point alignment: all terms share the same binary point, so the stage does plain integer addition with no shifting.
- `calculate_en` low leaves all state unchanged. Gaps between terms are allowed.

## Timing
- Reset values: `sum`=0, `sum_valid`=0, `busy`=0, `overflow`=0, state=IDLE, acc=0, cnt=0.
- Latency: `sum_valid` rises 1 cycle after the edge that samples the final term.
- Throughput: one term per clock. A group takes termCount cycles minimum.
- `busy` rises the cycle after term 1 is accepted. It falls in the same cycle `sum_valid` rises.
- `reset_n` asserted mid-group returns every register to its reset value immediately, with no pending pulse. The first edge after deassertion may accept term 1.

## Configuration
- `FIXED_ACCUMULATE_SATURATION_EN` defined:
  - The final W+G sum is checked against the signed W-bit range.
  - Positive excess gives `sum` = 0x7FFF_FFFF (for W=32).
  - Negative excess gives `sum` = 0x8000_0000.
  - `overflow` is 1 on either clamp, otherwise 0.
- Macro undefined:
  - `sum` is the low W bits of the internal sum (wrap-around).
  - `overflow` is tied to 0.
  - No comparator logic is generated.

## Test plan
- 8 × `product`=0x0001_8000 (1.5), consecutive cycles -> one cycle later `sum`=0x000C_0000, `sum_valid` pulse, `overflow`=0, `busy` low.
- 8 × 0xFFFF_0000 (−1.0) with random idle gaps -> `sum`=0xFFF8_0000, exactly one `sum_valid`.
- 8 × 0x7000_0000 -> with macro, `sum`=0x7FFF_FFFF and `overflow`=1; without macro, `sum`=0x8000_0000 and `overflow`=0. Same check for 8 × 0x9000_0000 with macro -> `sum`=0x8000_0000 and `overflow`=1.
- 3 terms of 0x0005_0000, then `clear` together with a strobe, then 8 × 0x0001_0000 -> `sum`=0x0008_0000. No pulse at the clear, and the strobe at the clear is discarded.
- Two groups back-to-back with no gap (8 × 1.0, then 8 × 2.0) -> pulses 8 cycles apart, `sum`=0x0008_0000 then 0x0010_0000.
- `reset_n` low after 5 terms, released, then 8 × 1.0 -> all outputs 0 during reset, then `sum`=0x0008_0000.
